// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched instructions with flush; head is read from registered storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    output fetch_entry_t       head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_incr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_incr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_incr(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; validity comes from count_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch: issues word fetches, queues responses for decode, and
// squashes in-flight responses after a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head, fifo_in;

    logic [CNT_W:0]   in_flight;
    logic [31:0]      redirect_base;
    logic             accept, resp_live;

    assign in_flight      = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign redirect_base  = redirect_pc & ~32'h3;
    assign imem_req_valid = !rst && !redirect_valid && (in_flight < (CNT_W + 1)'(FQ_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding belongs to a request issued before reset.
    assign resp_live      = imem_resp_valid && (outstanding_q != '0);
    assign fifo_in        = '{pc: resp_pc_q, instr: imem_resp_data};
    assign fifo_pop       = id_valid && id_ready && !redirect_valid;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d    = redirect_base;
            resp_pc_d     = redirect_base;
            fifo_flush    = 1'b1;
            outstanding_d = outstanding_q - CNT_W'(resp_live);
            drop_cnt_d    = outstanding_d;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
            if (resp_live) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - 1'b1;
                end else if (!fifo_full) begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
            outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(resp_live);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign id_valid = !fifo_empty;
    assign id_instr = id_valid ? fifo_head.instr : INSTR_NOP;
    assign id_pc    = id_valid ? fifo_head.pc    : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based model of the fetch rules.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid, id_ready = 1'b0;
    logic [31:0] id_instr, id_pc;

    logic        w_rst = 1'b1;
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_resp_valid = 1'b0;
    logic [31:0] w_resp_data = '0;
    logic        w_id_valid;
    logic [31:0] w_id_instr, w_id_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst(w_rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .id_valid(w_id_valid), .id_ready(1'b1), .id_instr(w_id_instr), .id_pc(w_id_pc)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_fetch, m_resp_pc;
    int          m_out, m_drop;
    logic [31:0] m_q_pc[$];
    logic [31:0] m_q_instr[$];

    // Memory environment: in-order responses, each due at least one cycle after acceptance
    logic [31:0] mem_addr[$];
    longint      mem_due[$];
    longint      cyc = 0;
    longint      last_due = 0;
    int          lat_min = 1, lat_max = 1;
    bit          stale_inject = 1'b0;

    logic [31:0] delivered[$];
    logic        obs_idv, obs_req;
    logic [31:0] obs_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    task automatic model_reset();
        m_fetch = 32'h0; m_resp_pc = 32'h0; m_out = 0; m_drop = 0;
        m_q_pc.delete(); m_q_instr.delete();
        mem_addr.delete(); mem_due.delete();
        last_due = cyc;
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic run_cycle(input bit r_v, input logic [31:0] r_pc, input bit i_r, input bit m_r);
        bit          exp_req, exp_idv, acc, resp_live, from_mem;
        logic [31:0] exp_pc, exp_instr, base;
        longint      due;
        redirect_valid = r_v; redirect_pc = r_pc; id_ready = i_r; imem_req_ready = m_r;
        imem_resp_valid = 1'b0; imem_resp_data = '0; from_mem = 1'b0;
        if (stale_inject) begin
            imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF; stale_inject = 1'b0;
        end else if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
            imem_resp_valid = 1'b1; imem_resp_data = instr_of(mem_addr[0]); from_mem = 1'b1;
        end
        #1;
        exp_req   = !r_v && (m_out + m_q_pc.size() < DEPTH);
        exp_idv   = m_q_pc.size() > 0;
        exp_pc    = exp_idv ? m_q_pc[0] : 32'h0;
        exp_instr = exp_idv ? m_q_instr[0] : INSTR_NOP;
        obs_idv = id_valid; obs_req = imem_req_valid; obs_addr = imem_req_addr;

        n_checks++;
        if (imem_req_valid !== exp_req) begin
            n_errors++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req);
        end
        n_checks++;
        if (imem_req_addr !== m_fetch) begin
            n_errors++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_fetch);
        end
        n_checks++;
        if (id_valid !== exp_idv || id_pc !== exp_pc || id_instr !== exp_instr) begin
            n_errors++;
            $display("FAIL id_out cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc,
                     id_valid, id_pc, id_instr, exp_idv, exp_pc, exp_instr);
        end

        if (id_valid && i_r && !r_v) delivered.push_back(id_pc);
        if (imem_req_valid && m_r) begin
            due = cyc + longint'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_addr.push_back(imem_req_addr); mem_due.push_back(due);
        end
        if (from_mem) begin
            void'(mem_addr.pop_front()); void'(mem_due.pop_front());
        end

        acc       = exp_req && m_r;
        resp_live = imem_resp_valid && (m_out > 0);
        if (r_v) begin
            base = {r_pc[31:2], 2'b00};
            m_fetch = base; m_resp_pc = base;
            m_q_pc.delete(); m_q_instr.delete();
            m_out  = m_out - int'(resp_live);
            m_drop = m_out;
        end else begin
            if (acc) m_fetch = m_fetch + 32'd4;
            if (exp_idv && i_r) begin
                void'(m_q_pc.pop_front()); void'(m_q_instr.pop_front());
            end
            if (resp_live) begin
                if (m_drop > 0) m_drop--;
                else begin
                    m_q_pc.push_back(m_resp_pc); m_q_instr.push_back(imem_resp_data);
                    m_resp_pc = m_resp_pc + 32'd4;
                end
            end
            m_out = m_out + int'(acc) - int'(resp_live);
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== INSTR_NOP ||
            id_pc !== 32'h0 || imem_req_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_values got=%b/%b/%h/%h/%h exp=0/0/00000013/0/0",
                     imem_req_valid, id_valid, id_instr, id_pc, imem_req_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int first_idv = -1;
        bit idv3 = 1'b0;
        lat_min = 1; lat_max = 1;
        delivered.delete();
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
            if (obs_idv && first_idv < 0) first_idv = i;
            if (i == 3) idv3 = obs_idv;
        end
        n_checks++;
        if (first_idv != 2 || !idv3) begin
            n_errors++; $display("FAIL stream_startup got=%0d/%b exp=2/1", first_idv, idv3);
        end
        n_checks++;
        if (delivered.size() < 3 || delivered[0] !== 32'h0 || delivered[1] !== 32'h4 ||
            delivered[2] !== 32'h8) begin
            n_errors++; $display("FAIL stream_pcs got_count=%0d exp first=0,4,8", delivered.size());
        end
    endtask

    task automatic test_backpressure();
        int start = delivered.size();
        bit ordered = 1'b1;
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (u_dut.u_fifo.count_o !== 2'd2 || obs_req !== 1'b0 || obs_idv !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure_hold got count=%0d req=%b idv=%b exp count=2 req=0 idv=1",
                     u_dut.u_fifo.count_o, obs_req, obs_idv);
        end
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = start + 1; i < delivered.size(); i++)
            if (delivered[i] !== delivered[i-1] + 32'd4) ordered = 1'b0;
        n_checks++;
        if (!ordered || delivered.size() < start + 4 || delivered[start] !== delivered[start-1] + 32'd4) begin
            n_errors++; $display("FAIL backpressure_order got delivered=%0d in_order=%b exp in_order=1",
                                 delivered.size() - start, ordered);
        end
    endtask

    task automatic test_redirect();
        int guard = 0;
        int mark;
        lat_min = 3; lat_max = 3;
        while (m_out != 2 && guard < 30) begin
            run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
            guard++;
        end
        n_checks++;
        if (m_out != 2) begin
            n_errors++; $display("FAIL redirect_setup got outstanding=%0d exp=2", m_out);
        end
        run_cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        mark = delivered.size();
        for (int i = 0; i < 15; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (delivered.size() <= mark || delivered[mark] !== 32'h100) begin
            n_errors++; $display("FAIL redirect_target got=%h exp=00000100",
                                 (delivered.size() > mark) ? delivered[mark] : 32'hx);
        end
    endtask

    task automatic test_misaligned();
        lat_min = 1; lat_max = 2;
        run_cycle(1'b1, 32'h0000_0203, 1'b1, 1'b1);
        run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (obs_addr !== 32'h200 || obs_req !== 1'b1) begin
            n_errors++; $display("FAIL misaligned_redirect got=%h/%b exp=00000200/1", obs_addr, obs_req);
        end
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++)
            run_cycle($urandom_range(99) < 6, $urandom, $urandom_range(3) != 0, $urandom_range(3) != 0);
    endtask

    task automatic test_reset_mid();
        int mark;
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== INSTR_NOP ||
            id_pc !== 32'h0 || imem_req_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset got=%b/%b/%h/%h/%h exp=0/0/00000013/0/0",
                     imem_req_valid, id_valid, id_instr, id_pc, imem_req_addr);
        end
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        stale_inject = 1'b1;
        mark = delivered.size();
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (delivered.size() <= mark || delivered[mark] !== 32'h0) begin
            n_errors++; $display("FAIL refetch_after_reset got=%h exp=00000000",
                                 (delivered.size() > mark) ? delivered[mark] : 32'hx);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] acc_addr[$];
        logic [31:0] ids[$];
        bit          pend = 1'b0;
        logic [31:0] pend_addr = '0;
        bit          instr_ok = 1'b1;
        @(posedge clk); #1;
        w_rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            w_resp_valid = pend; w_resp_data = pend_addr;
            #1;
            if (w_id_valid) begin
                ids.push_back(w_id_pc);
                if (w_id_instr !== w_id_pc) instr_ok = 1'b0;
            end
            pend = w_req_valid;
            if (w_req_valid) begin
                pend_addr = w_req_addr; acc_addr.push_back(w_req_addr);
            end
            @(posedge clk); #1;
        end
        w_resp_valid = 1'b0;
        n_checks++;
        if (acc_addr.size() < 3 || acc_addr[0] !== 32'hFFFF_FFF8 || acc_addr[1] !== 32'hFFFF_FFFC ||
            acc_addr[2] !== 32'h0) begin
            n_errors++; $display("FAIL wrap_addr got first=%h count=%0d exp=FFFFFFF8,FFFFFFFC,00000000",
                                 (acc_addr.size() > 0) ? acc_addr[0] : 32'hx, acc_addr.size());
        end
        n_checks++;
        if (ids.size() < 3 || ids[0] !== 32'hFFFF_FFF8 || ids[1] !== 32'hFFFF_FFFC ||
            ids[2] !== 32'h0 || !instr_ok) begin
            n_errors++; $display("FAIL wrap_id_pc got count=%0d instr_ok=%b exp=FFFFFFF8,FFFFFFFC,00000000",
                                 ids.size(), instr_ok);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL provide parameter FQ_DEPTH, default 2, the fetch-queue depth and the maximum number of requests in flight.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port: imem_req_ready  input  1  memory accepts the request.
REQ-008 SHALL have port: imem_req_addr  output  32  word-aligned fetch address.
REQ-009 SHALL have port: imem_resp_valid  input  1  instruction returned; responses are in order, at least 1 cycle after acceptance, with no backpressure.
REQ-010 SHALL have port: imem_resp_data  input  32  returned instruction word.
REQ-011 SHALL have port: redirect_valid  input  1  branch/jump redirect from execute.
REQ-012 SHALL have port: redirect_pc  input  32  redirect target.
REQ-013 SHALL have port: id_valid  output  1  instruction available to decode.
REQ-014 SHALL have port: id_ready  input  1  decode accepts the instruction.
REQ-015 SHALL have port: id_instr  output  32  instruction word to decode and the immediate generator.
REQ-016 SHALL have port: id_pc  output  32  PC of id_instr.

Function
REQ-017 SHALL hold fetch_pc; imem_req_addr = fetch_pc.
REQ-018 SHALL assert imem_req_valid = !rst && !redirect_valid && (outstanding + queue_count < FQ_DEPTH), so the queue never overflows.
REQ-019 SHALL accept a request on imem_req_valid && imem_req_ready: fetch_pc += 4 (modulo 2^32, wrapping at 32'hFFFF_FFFC -> 0) and outstanding += 1.
REQ-020 SHALL decrement outstanding on each imem_resp_valid; with simultaneous accept and response, outstanding is unchanged.
REQ-021 SHALL push {resp_pc, imem_resp_data} into the queue on a non-dropped response, then resp_pc += 4.
REQ-022 SHALL present the queue head as id_valid/id_instr/id_pc and pop it on id_valid && id_ready; push and pop in the same cycle are both performed.
REQ-023 SHALL drive id_instr = 32'h0000_0013 (NOP) and id_pc = 0 while id_valid = 0.
REQ-024 SHALL, on redirect_valid, in the same edge: set fetch_pc and resp_pc to {redirect_pc[31:2], 2'b00}, flush the queue, and set drop_cnt = outstanding minus any response arriving that cycle.
REQ-025 SHALL discard responses while drop_cnt > 0, decrementing drop_cnt without pushing.
REQ-026 SHALL ignore an id pop in a redirect cycle, since the queue is flushed.
REQ-027 SHALL treat a redirect arriving while drop_cnt > 0 as REQ-024, recomputing drop_cnt from the current outstanding.
REQ-028 SHALL keep first-fetch-to-id_valid latency at memory latency + 1 cycle; the queue output is registered.

Reset
REQ-029 SHALL, while rst is high, set fetch_pc = RESET_PC, resp_pc = RESET_PC, outstanding = 0, drop_cnt = 0, queue empty, imem_req_valid = 0, id_valid = 0, id_instr = NOP, id_pc = 0.
REQ-030 SHALL discard all in-flight state on reset mid-operation, and SHALL ignore responses for requests issued before reset.
REQ-031 SHALL issue the first request at RESET_PC in the first cycle after rst deasserts.

Structure
REQ-032 SHALL define in shared package fetch_pkg: the INSTR_NOP constant, the RESET_PC default, and typedef fetch_entry_t {pc[31:0], instr[31:0]}.
REQ-033 SHALL implement the queue as sub-module fetch_fifo, a synchronous FQ_DEPTH-entry FIFO of fetch_entry_t with flush, full, empty and count.

Verification
REQ-034 SHALL verify the streaming case: ready = 1, 1-cycle memory, id_ready = 1 -> id_pc sequence 0x0, 0x4, 0x8 with back-to-back id_valid after a 2-cycle startup.
REQ-035 SHALL verify decode backpressure: id_ready = 0 for 10 cycles -> exactly 2 entries held, imem_req_valid = 0, no loss; on release, PCs continue in order.
REQ-036 SHALL verify a redirect to 0x100 with 2 requests in flight -> both responses dropped, next id_pc = 0x100, no stale instruction delivered.
REQ-037 SHALL verify a misaligned redirect to 0x203 -> imem_req_addr = 0x200.
REQ-038 SHALL verify wrap-around: RESET_PC = 0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-039 SHALL verify reset asserted mid-stream -> outputs take reset values asynchronously, and refetch starts at RESET_PC.
